// File: rtl/tea_uart_sequencer_if.sv
// rtl/tea_uart_sequencer_if.sv - bus bundle between UART, sequencer and TEA core
interface tea_uart_sequencer_if #(
  parameter int KEY_BYTES = 16,
  parameter int BLK_BYTES = 8
);
  logic                   rx_valid;
  logic [7:0]             rx_data;
  logic [KEY_BYTES*8-1:0] key;
  logic [BLK_BYTES*8-1:0] blk;
  logic                   core_mode;
  logic                   core_start;
  logic                   core_done;
  logic [BLK_BYTES*8-1:0] core_result;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   busy;
  logic                   err;

  // Sequencer side
  modport master (
    input  rx_valid, rx_data, core_done, core_result, tx_ready,
    output key, blk, core_mode, core_start, tx_data, tx_valid, busy, err
  );

  // Environment side: UART receiver/transmitter and TEA core
  modport slave (
    output rx_valid, rx_data, core_done, core_result, tx_ready,
    input  key, blk, core_mode, core_start, tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/tea_uart_sequencer.sv
// rtl/tea_uart_sequencer.sv - UART frame parser and TEA core launch/result sequencer
module tea_uart_sequencer #(
  parameter int KEY_BYTES = 16,
  parameter int BLK_BYTES = 8
) (
  input logic                   clk,
  input logic                   rst,
  tea_uart_sequencer_if.master  bus
);
  localparam int KW = KEY_BYTES * 8;
  localparam int BW = BLK_BYTES * 8;
  localparam logic [4:0] KEY_LAST = 5'(KEY_BYTES - 1);
  localparam logic [4:0] BLK_LAST = 5'(BLK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_BLK, S_START, S_WAIT, S_SEND
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [KW-1:0] shadow_q, shadow_d;
  logic [KW-1:0] key_q, key_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [BW-1:0] out_q, out_d;
  logic          mode_q, mode_d;
  logic          start_q, start_d;
  logic          txv_q, txv_d;
  logic          err_q, err_d;
  logic          tx_fire;

  assign tx_fire = txv_q && bus.tx_ready;

  // State and datapath registers; reset also wipes the committed key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      blk_q    <= '0;
      out_q    <= '0;
      mode_q   <= 1'b0;
      start_q  <= 1'b0;
      txv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      blk_q    <= blk_d;
      out_q    <= out_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      txv_q    <= txv_d;
      err_q    <= err_d;
    end
  end

  // Next-state decode: command parse, payload shifting, launch and result streaming
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    blk_d    = blk_q;
    out_d    = out_q;
    mode_d   = mode_q;
    start_d  = 1'b0;
    txv_d    = txv_q;
    err_d    = 1'b0;

    // Bytes arriving while the core owns the operands are dropped and flagged
    if (bus.rx_valid && (state_q == S_START || state_q == S_WAIT || state_q == S_SEND)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h4B: begin
              state_d = S_KEY;
              cnt_d   = '0;
            end
            8'h45: begin
              state_d = S_BLK;
              cnt_d   = '0;
              mode_d  = 1'b0;
            end
            8'h44: begin
              state_d = S_BLK;
              cnt_d   = '0;
              mode_d  = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_KEY: begin
        if (bus.rx_valid) begin
          shadow_d = {shadow_q[KW-9:0], bus.rx_data};
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == KEY_LAST) begin
            // Commit the whole key at once so the core never sees a partial key
            key_d   = {shadow_q[KW-9:0], bus.rx_data};
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      S_BLK: begin
        if (bus.rx_valid) begin
          blk_d = {blk_q[BW-9:0], bus.rx_data};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == BLK_LAST) begin
            state_d = S_START;
            cnt_d   = '0;
            start_d = 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          out_d   = bus.core_result;
          txv_d   = 1'b1;
          state_d = S_SEND;
          cnt_d   = '0;
        end
      end
      S_SEND: begin
        if (tx_fire) begin
          out_d = {out_q[BW-9:0], 8'h00};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == BLK_LAST) begin
            txv_d   = 1'b0;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.key        = key_q;
  assign bus.blk        = blk_q;
  assign bus.core_mode  = mode_q;
  assign bus.core_start = start_q;
  assign bus.tx_data    = out_q[BW-1:BW-8];
  assign bus.tx_valid   = txv_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule
